// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_MAX_D_BURST = 4;
   localparam int unsigned DEF_TIMEOUT     = 64;
   localparam int unsigned BURST_W         = 4;

endpackage

// File: rtl/arb_priority_pick.sv
// Winner select between fetch and data, plus next value of the data burst counter.
// Purely combinational; the caller applies burst_nxt only when it issues a grant.
module arb_priority_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_D_BURST = DEF_MAX_D_BURST
) (
   input  logic               if_req,
   input  logic               d_req,
   input  logic [BURST_W-1:0] burst_cnt,
   output logic               grant,
   output owner_t             winner,
   output logic [BURST_W-1:0] burst_nxt
);

   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

   logic fetch_due;

   assign fetch_due = if_req && (burst_cnt >= BURST_MAX);

   always_comb begin
      grant     = if_req || d_req;
      winner    = OWN_IF;
      burst_nxt = burst_cnt;
      if (d_req && !fetch_due) begin
         winner = OWN_D;
         // only data grants that make a waiting fetch wait longer are counted
         if (!if_req) begin
            burst_nxt = '0;
         end else if (burst_cnt != '1) begin
            burst_nxt = burst_cnt + 1'b1;
         end
      end else if (if_req) begin
         burst_nxt = '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one req/ack memory port; ack 2 cycles after grant with a zero-wait memory.
// Requesters hold req until their ack; stall_o covers every pending request. Watchdog: MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned MAX_D_BURST = DEF_MAX_D_BURST,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              err_o
);

   if (MAX_D_BURST < 1 || MAX_D_BURST > 15 || TIMEOUT < 1) begin : g_param_check
      $error("mem_port_arbiter: MAX_D_BURST must be 1..15 and TIMEOUT at least 1");
   end

   state_t             state, state_nxt;
   owner_t             owner, winner;
   logic [BURST_W-1:0] burst_cnt, burst_nxt;
   logic               grant, issue, finish, abort;

   arb_priority_pick #(
      .MAX_D_BURST (MAX_D_BURST)
   ) u_pick (
      .if_req    (if_req_i),
      .d_req     (d_req_i),
      .burst_cnt (burst_cnt),
      .grant     (grant),
      .winner    (winner),
      .burst_nxt (burst_nxt)
   );

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

   logic [WDOG_W-1:0] wdog;

   // wdog holds the index of the current BUSY cycle, starting at 0
   assign abort = (state == BUSY) && !mem_ack_i && (wdog == WDOG_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || state != BUSY) begin
         wdog  <= '0;
      end else if (wdog != '1) begin
         wdog  <= wdog + 1'b1;
      end
      err_o <= rst_i ? 1'b0 : abort;
   end
`else
   assign abort = 1'b0;
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant) state_nxt = BUSY;
         BUSY:    if (mem_ack_i || abort) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue  = (state == IDLE) && grant;
      finish = (state == BUSY) && (mem_ack_i || abort);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner       <= OWN_IF;
         burst_cnt   <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_ack_o    <= 1'b0;
         d_ack_o     <= 1'b0;
         if_rdata_o  <= '0;
         d_rdata_o   <= '0;
      end else begin
         if_ack_o <= finish && (owner == OWN_IF);
         d_ack_o  <= finish && (owner == OWN_D);
         if (issue) begin
            owner       <= winner;
            burst_cnt   <= burst_nxt;
            mem_req_o   <= 1'b1;
            mem_we_o    <= (winner == OWN_D) && d_we_i;
            mem_addr_o  <= (winner == OWN_D) ? d_addr_i : if_addr_i;
            mem_wdata_o <= (winner == OWN_D) ? d_wdata_i : '0;
         end
         if (finish) begin
            mem_req_o <= 1'b0;
            // an aborted access returns zero; a completed write leaves read data alone
            if (owner == OWN_IF) begin
               if_rdata_o <= abort ? '0 : mem_rdata_i;
            end else if (abort || !mem_we_o) begin
               d_rdata_o  <= abort ? '0 : mem_rdata_i;
            end
         end
      end
   end

   assign stall_o = (if_req_i && !if_ack_o) || (d_req_i && !d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXB = 4;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam int TMO    = 8;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 64;
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0, rst_i = 1'b1;
   logic          if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0, mem_ack_i = 1'b0;
   logic [AW-1:0] if_addr_i = '0, d_addr_i = '0;
   logic [DW-1:0] d_wdata_i = '0, mem_rdata_i = '0;
   logic          if_ack_o, d_ack_o, mem_req_o, mem_we_o, stall_o, err_o;
   logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
   logic [AW-1:0] mem_addr_o;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
   typedef struct packed { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } glog_t;
   typedef struct packed { int cyc; logic is_d; logic [DW-1:0] rdata; } alog_t;

   int n_tests = 0, n_fail = 0, cyc = 0;
   bit chk_en = 1'b0;

   // requester queues, memory knobs
   req_t if_q[$], d_q[$];
   bit   auto_en = 0, spur_en = 0, rd_fix_en = 0;
   int   lat_min = 0, lat_max = 0, wait_left = 0, rate_if = 0, rate_d = 0, if_raise = 0, d_raise = 0;
   logic [DW-1:0] rd_fix = '0;

   // transaction-level reference: one access open at a time, done once the memory answers
   bit   m_open = 0, m_done = 0, m_abort = 0, m_own_d = 0;
   req_t m_txn = '0;
   int   m_burst = 0, m_busy_n = 0;
   logic [DW-1:0] m_if_rdata = '0, m_d_rdata = '0;
   bit   ev_if_done = 0, ev_d_done = 0, ev_grant = 0, ev_rst = 0;

   glog_t grant_log[$];
   alog_t ack_log[$];
   int    stall_hi = 0, err_n = 0;
   logic  req_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic [DW-1:0] rd;
      ev_if_done = 0; ev_d_done = 0; ev_grant = 0; ev_rst = rst_i;
      if (rst_i) begin
         m_open = 0; m_done = 0; m_abort = 0; m_burst = 0; m_if_rdata = '0; m_d_rdata = '0;
         return;
      end
      if (m_open && m_done) begin
         m_open = 0;
         if (m_own_d) ev_d_done = 1; else ev_if_done = 1;
      end else if (m_open) begin
         m_busy_n++;
         if (mem_ack_i || (TMO_EN && m_busy_n == TMO)) begin
            m_done  = 1;
            m_abort = !mem_ack_i;
            rd      = m_abort ? '0 : mem_rdata_i;
            if (!m_own_d) m_if_rdata = rd;
            else if (!m_txn.we || m_abort) m_d_rdata = rd;
         end
      end else if (if_req_i || d_req_i) begin
         m_own_d = d_req_i && !(if_req_i && m_burst == MAXB);
         if (m_own_d) begin
            m_txn   = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i};
            m_burst = if_req_i ? m_burst + 1 : 0;
         end else begin
            m_txn   = '{we: 1'b0, addr: if_addr_i, wdata: '0};
            m_burst = 0;
         end
         m_open = 1; m_done = 0; m_abort = 0; m_busy_n = 0; ev_grant = 1;
      end
   endtask

   task automatic drive();
      req_t r;
      if (ev_rst) begin
         if_req_i = 0; d_req_i = 0; mem_ack_i = 0; wait_left = 0;
         return;
      end
      if (!if_req_i || ev_if_done) begin
         if_req_i = 0;
         if (if_q.size() != 0) begin
            r = if_q.pop_front(); if_req_i = 1; if_addr_i = r.addr; if_raise = cyc;
         end else if (auto_en && $urandom_range(99) < rate_if) begin
            if_req_i = 1; if_addr_i = $urandom & ~32'h3; if_raise = cyc;
         end
      end
      if (!d_req_i || ev_d_done) begin
         d_req_i = 0;
         if (d_q.size() != 0) begin
            r = d_q.pop_front(); d_req_i = 1; d_we_i = r.we; d_addr_i = r.addr; d_wdata_i = r.wdata; d_raise = cyc;
         end else if (auto_en && $urandom_range(99) < rate_d) begin
            d_req_i = 1; d_we_i = $urandom_range(1); d_addr_i = $urandom & ~32'h3; d_wdata_i = $urandom; d_raise = cyc;
         end
      end
      mem_ack_i   = 0;
      mem_rdata_i = $urandom;
      if (m_open && !m_done) begin
         if (ev_grant) wait_left = $urandom_range(lat_max, lat_min);
         if (wait_left == 0) begin
            mem_ack_i = 1;
            if (rd_fix_en) mem_rdata_i = rd_fix;
         end else begin
            wait_left--;
         end
      end else if (spur_en && $urandom_range(7) == 0) begin
         mem_ack_i = 1;
      end
   endtask

   always @(posedge clk) begin
      model_step();
      cyc++;
      #1;
      drive();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_req", mem_req_o, m_open && !m_done);
         if (m_open && !m_done) begin
            check("mem_we", mem_we_o, m_txn.we);
            check("mem_addr", mem_addr_o, m_txn.addr);
            if (m_own_d) check("mem_wdata", mem_wdata_o, m_txn.wdata);
         end
         check("if_ack", if_ack_o, m_open && m_done && !m_own_d);
         check("d_ack", d_ack_o, m_open && m_done && m_own_d);
         check("if_rdata", if_rdata_o, m_if_rdata);
         check("d_rdata", d_rdata_o, m_d_rdata);
         check("stall", stall_o, (if_req_i && !(m_open && m_done && !m_own_d)) ||
                                 (d_req_i && !(m_open && m_done && m_own_d)));
         check("err", err_o, m_open && m_done && m_abort);
      end
      if (mem_req_o && !req_prev) grant_log.push_back('{cyc: cyc, we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o});
      req_prev = mem_req_o;
      if (if_ack_o) ack_log.push_back('{cyc: cyc, is_d: 1'b0, rdata: if_rdata_o});
      if (d_ack_o)  ack_log.push_back('{cyc: cyc, is_d: 1'b1, rdata: d_rdata_o});
      if (stall_o) stall_hi++;
      if (err_o) err_n++;
   end

   task automatic clear_logs();
      grant_log.delete(); ack_log.delete(); stall_hi = 0; err_n = 0;
   endtask

   task automatic settle(input string name, input int budget);
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while ((if_q.size() != 0 || d_q.size() != 0 || m_open || if_req_i || d_req_i) && n < budget);
      repeat (2) @(negedge clk);
      check({name, "_done_in_budget"}, n < budget, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [AW-1:0] exp_seq [10];
      repeat (3) @(posedge clk);
      #1 rst_i = 0;
      chk_en = 1;
      @(negedge clk);
      check("rst_mem_req", mem_req_o, 1'b0);
      check("rst_mem_addr", mem_addr_o, 32'h0);
      check("rst_acks", {if_ack_o, d_ack_o, err_o, stall_o, mem_we_o}, 5'b0);
      check("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);

      // single fetch, zero-wait memory
      clear_logs(); lat_min = 0; lat_max = 0; rd_fix_en = 1; rd_fix = 32'h00A00093;
      if_q.push_back('{we: 1'b0, addr: 32'h40, wdata: '0});
      settle("t1", 40);
      rd_fix_en = 0;
      check("t1_grants", grant_log.size(), 1);
      check("t1_addr", grant_log[0].addr, 32'h40);
      check("t1_we", grant_log[0].we, 1'b0);
      check("t1_req_lat", grant_log[0].cyc - if_raise, 1);
      check("t1_acks", ack_log.size(), 1);
      check("t1_ack_lat", ack_log[0].cyc - if_raise, 2);
      check("t1_ack_owner", ack_log[0].is_d, 1'b0);
      check("t1_rdata", ack_log[0].rdata, 32'h00A00093);
      check("t1_stall_cycles", stall_hi, 2);

      // simultaneous data write and fetch: data first
      clear_logs();
      d_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF});
      if_q.push_back('{we: 1'b0, addr: 32'h44, wdata: '0});
      settle("t2", 40);
      check("t2_grants", grant_log.size(), 2);
      check("t2_first", {grant_log[0].we, grant_log[0].addr, grant_log[0].wdata}, {1'b1, 32'h100, 32'hDEADBEEF});
      check("t2_second", {grant_log[1].we, grant_log[1].addr}, {1'b0, 32'h44});
      check("t2_acks", ack_log.size(), 2);
      check("t2_ack_order", {ack_log[0].is_d, ack_log[1].is_d}, 2'b10);

      // starvation bound: fetch gets in after every MAXB data grants
      clear_logs(); lat_min = 0; lat_max = 2;
      for (int i = 0; i < 8; i++) d_q.push_back('{we: 1'b0, addr: 32'h1000 + 4 * i, wdata: 32'h0});
      if_q.push_back('{we: 1'b0, addr: 32'h80, wdata: '0});
      if_q.push_back('{we: 1'b0, addr: 32'h84, wdata: '0});
      exp_seq = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h80,
                  32'h1010, 32'h1014, 32'h1018, 32'h101C, 32'h84};
      settle("t3", 200);
      check("t3_grants", grant_log.size(), 10);
      for (int i = 0; i < 10; i++) check($sformatf("t3_grant%0d", i), grant_log[i].addr, exp_seq[i]);

      // wait-state memory
      clear_logs(); lat_min = 5; lat_max = 5;
      d_q.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h12345678});
      settle("t4", 60);
      check("t4_acks", ack_log.size(), 1);
      check("t4_ack_lat", ack_log[0].cyc - grant_log[0].cyc, 6);
      check("t4_stall_cycles", stall_hi, 7);

      // reset in the middle of BUSY
      clear_logs(); lat_min = 30; lat_max = 30;
      d_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
      for (int i = 0; i < 20 && grant_log.size() == 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_i = 1;
      @(posedge clk); #1 rst_i = 0;
      @(negedge clk);
      check("t5_req_dropped", mem_req_o, 1'b0);
      repeat (5) @(negedge clk);
      check("t5_no_ack", ack_log.size(), 0);
      lat_min = 1; lat_max = 1;
      if_q.push_back('{we: 1'b0, addr: 32'h500, wdata: '0});
      settle("t5", 40);
      check("t5_fresh_ack", ack_log.size(), 1);
      check("t5_fresh_owner", ack_log[0].is_d, 1'b0);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      // memory never answers
      clear_logs(); lat_min = 1000; lat_max = 1000;
      d_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0});
      settle("t6", 60);
      check("t6_acks", ack_log.size(), 1);
      check("t6_owner", ack_log[0].is_d, 1'b1);
      check("t6_rdata", ack_log[0].rdata, 32'h0);
      check("t6_err", err_n, 1);
      check("t6_lat", ack_log[0].cyc - grant_log[0].cyc, 8);
`endif

      // random traffic with wait states and stray memory acks
      clear_logs(); lat_min = 0; lat_max = 6; spur_en = 1; rate_if = 30; rate_d = 40; auto_en = 1;
      repeat (3000) @(negedge clk);
      auto_en = 0;
      settle("rand", 200);
      spur_en = 0;
      check("rand_acks_eq_grants", ack_log.size(), grant_log.size());
      check("rand_had_traffic", grant_log.size() > 100, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between two requesters: the instruction-fetch stage (read only) and the MEM-stage data access (read/write).
- Serialises their accesses with a req/ack handshake toward the memory.
- Returns per-requester ack pulses and read data.
- Drives a pipeline stall while any request is outstanding. It sits between the pipelined CPU core and the memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_BURST, 4, max consecutive data grants while fetch waits (range 1..15)
- TIMEOUT, 64, cycles without mem_ack_i before abort (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetch data, valid with if_ack_o
- d_req_i  in  1  data request; held until d_ack_o
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  read data, valid with d_ack_o
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion, one cycle
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- stall_o  out  1  pipeline stall
- err_o  out  1  timeout error pulse (tied 0 when the optional feature is absent)

Behaviour:
- FSM states: IDLE, BUSY, RESP. The reset state is IDLE.
- Reset values: all outputs 0, burst counter 0, owner = fetch.
- Reset asserted mid-transaction: return to IDLE at once; mem_req_o drops the next cycle; no ack pulse is issued.
- IDLE: if any request is present, pick a winner, register mem_req_o=1 and mem_we_o/mem_addr_o/mem_wdata_o from the winner, and go to BUSY. With no request, stay in IDLE.
- mem_we_o is 0 for fetch grants.
- Arbitration: data wins over fetch, unless burst counter = MAX_D_BURST and if_req_i=1; then fetch wins.
- Burst counter: incremented on each data grant made while if_req_i=1; cleared on any fetch grant or when if_req_i=0 at a data grant.
- BUSY: mem_* outputs are held stable. On mem_ack_i=1, latch mem_rdata_i into the owner's rdata register, drive the owner's ack=1 on the next cycle, clear mem_req_o, and go to RESP.
- RESP: exactly one cycle with the owner's ack=1. No arbitration happens in RESP, so a still-high req from the just-acked requester is never double-granted. Then go to IDLE.
- Write acks: d_rdata_o keeps its previous value.
- Latency: request sampled in IDLE at cycle 0 → mem_req_o at cycle 1 → with a zero-wait memory (ack in cycle 1), ack pulse at cycle 2. Next grant is visible at cycle 4 at the earliest.
- Requester drop: if the requester deasserts req during BUSY, the access still completes and the ack is still pulsed. Requesters must not do this.
- mem_ack_i outside BUSY is ignored.
- stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o), combinational from inputs and registered acks.
- Both requests arriving in the same IDLE cycle: data is granted; fetch waits until RESP→IDLE.
- Counters are saturating; no wrap-around.

Optional Feature:
- Macro: MEM_PORT_ARBITER_TIMEOUT_EN.
- Defined: a watchdog counter runs in BUSY. If it reaches TIMEOUT with no mem_ack_i, then:
  - mem_req_o drops;
  - err_o pulses for one cycle;
  - the owner's ack pulses with rdata = 0;
  - the FSM goes to RESP.
- If mem_ack_i arrives in the same cycle the count reaches TIMEOUT, the ack wins and err_o stays 0.
- Undefined: no counter; BUSY waits indefinitely; err_o is tied 0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the owner enum (OWN_IF, OWN_D);
  - default constants for ADDR_W, DATA_W, MAX_D_BURST, TIMEOUT.
- Sub-module: arb_priority_pick, the combinational winner select plus burst counter update, instantiated once.

Test Plan:
- Single fetch, zero-wait memory: if_req_i=1, if_addr_i=0x40, mem_ack_i in the first BUSY cycle with rdata 0x00A00093 → mem_addr_o=0x40, mem_we_o=0, if_ack_o at cycle 2 with if_rdata_o=0x00A00093, stall_o high cycles 0–1.
- Simultaneous fetch and data write: d addr 0x100 wdata 0xDEADBEEF, fetch addr 0x44 → data served first (mem_we_o=1, addr 0x100), then fetch (addr 0x44). d_ack_o precedes if_ack_o; neither ack fires twice.
- Starvation bound: d_req_i held with a new request each time while if_req_i stays high, MAX_D_BURST=4 → exactly 4 data grants, then a fetch grant, then the counter resets.
- Wait-state memory: mem_ack_i delayed 5 cycles → mem_addr_o/mem_wdata_o stable for all 5 cycles, ack exactly one cycle, stall_o high throughout.
- Reset mid-BUSY: rst_i pulsed during BUSY → mem_req_o=0 the next cycle, no ack, FSM in IDLE; a fresh request afterwards completes normally.
- With MEM_PORT_ARBITER_TIMEOUT_EN, TIMEOUT=8, memory never acks → err_o and d_ack_o pulse once after 8 BUSY cycles, d_rdata_o=0.
